cla_pipelined_adder: RTL and testbench
======================================

Name: cla_pipelined_adder

Overview:
- Parametrised, two-stage pipelined carry-lookahead adder/subtractor with valid/ready flow control.
- Generalises the fixed 4-bit lookahead unit to WIDTH bits using a two-level lookahead: 4-bit groups, then a second-level lookahead across groups.
- Adds add/subtract mode, signed overflow, backpressure and a full-throughput pipeline.
- Sits in the arithmetic cla_family as the datapath adder for wider ALUs.

Parameters:
- WIDTH, 32, operand width; multiple of 4, range 4..64.
- NGRP, WIDTH/4, number of 4-bit groups; derived, not overridable.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operands and mode are valid this cycle.
- in_ready  output  1  block accepts the operand beat this cycle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in; ignored when sub=1.
- sub  input  1  0: A+B+cin; 1: A-B (A + ~B + 1).
- out_valid  output  1  result beat valid.
- out_ready  input  1  downstream accepts the result.
- sum  output  WIDTH  result, modulo 2^WIDTH.
- cout  output  1  carry-out of the MSB. For subtraction, 1 means no borrow.
- ovf  output  1  signed overflow: carry into MSB XOR carry out of MSB.

Behaviour:
- Reset (async, rst=1):
  - s1_valid=0, out_valid=0.
  - sum=0, cout=0, ovf=0.
  - in_ready=1 from the first cycle after reset deasserts.
- Transfers:
  - An input transfer occurs when in_valid & in_ready on a rising clk.
  - An output transfer occurs when out_valid & out_ready on a rising clk.
- Stage 1 (registered at input transfer):
  - Compute bb = sub ? ~b : b and c0 = sub ? 1 : cin.
  - Compute per-bit p = a^bb and g = a&bb.
  - Compute per-group GG/GP: GG = G3|P3G2|P3P2G1|P3P2P1G0, GP = P3P2P1P0.
  - Register p, g, GG, GP, c0 and s1_valid.
- Stage 2 (registered into the output regs):
  - Second-level lookahead over NGRP groups produces group carry-ins.
  - Each group's internal carries are computed with the 4-bit lookahead equations.
  - sum = p ^ carries; cout = carry out of bit WIDTH-1; ovf = c[WIDTH-1] ^ c[WIDTH].
  - Bit-level ripple is not permitted in any stage.
- Latency and throughput:
  - Latency is exactly 2 cycles: a beat accepted at edge N is valid at the outputs after edge N+1 when unstalled.
  - Throughput is 1 beat/cycle when out_ready=1.
- Flow control:
  - s2_adv = !out_valid | out_ready.
  - s1_adv = !s1_valid | s2_adv.
  - in_ready = s1_adv, combinational with no dependency on in_valid.
  - When stalled, sum/cout/ovf/out_valid hold stable until accepted.
- Ordering and occupancy:
  - Results leave in acceptance order.
  - Max 2 beats in flight; none dropped or duplicated.
- Simultaneous events:
  - When stage 2 drains and stage 1 accepts on the same edge, both moves occur.
  - If out_ready=1 with s1 empty, out_valid falls to 0 after the edge; sum keeps its last value.
- Reset mid-operation:
  - All in-flight beats are discarded.
  - Outputs return to reset values immediately (asynchronous).
- Data while idle: sum/cout/ovf are don't-care when out_valid=0, except after reset, when they are 0.

Decomposition:
- Shared package cla_pkg holds:
  - the GRP_W=4 constant;
  - a function computing the NGRP carry vector from GG/GP/c0;
  - a WIDTH-legality check (WIDTH%4==0, 4<=WIDTH<=64), asserted at elaboration.
- One sub-module, cla_group_lookahead:
  - 4-bit G/P/c_in in; carries C[4:1], GG and GP out; purely combinational.
  - Instantiated NGRP times in stage 1 (GG/GP) and reused in stage 2 (internal carries).

Test Plan:
- WIDTH=32, a=0xFFFFFFFF, b=0, cin=1, sub=0 -> sum=0x00000000, cout=1, ovf=0, two cycles after acceptance.
- a=5, b=7, sub=1 -> sum=0xFFFFFFFE, cout=0, ovf=0; a=0x7FFFFFFF, b=1, sub=0 -> sum=0x80000000, ovf=1, cout=0.
- 8 back-to-back beats with out_ready=1 -> in_ready stays 1; 8 results on 8 consecutive cycles starting cycle 2; order preserved.
- Hold out_ready=0 while issuing 3 beats -> in_ready=0 after the 2nd acceptance. The held result stays stable. Release: all 3 emerge in order, none lost.
- Assert rst while 2 beats are in flight -> out_valid=0 and sum=0 immediately. After release, a new beat 1+2 -> sum=3 at latency 2.
- Random regression over WIDTH=4, 16, 64, 10k beats with random in_valid/out_ready -> sum/cout/ovf match a behavioural a±b model for every beat.

Source files
------------

// File: rtl/cla_pkg.sv
// Shared constants and helpers for the cla_family adders: group size,
// the second-level carry lookahead across groups, and the width legality check.
package cla_pkg;

    localparam int GRP_W   = 4;
    localparam int MAX_GRP = 16;

    function automatic bit width_ok(input int w);
        return (w % GRP_W == 0) && (w >= 4) && (w <= 64);
    endfunction

    // Group carry-ins as a flat sum of products: c[i+1] = GG[i] | GP[i]GG[i-1] | ... | GP[i..0]c0.
    function automatic logic [MAX_GRP:0] group_carries(input logic [MAX_GRP-1:0] gg,
                                                       input logic [MAX_GRP-1:0] gp,
                                                       input logic               c0);
        logic [MAX_GRP:0] c;
        logic             term;
        c    = '0;
        c[0] = c0;
        for (int i = 0; i < MAX_GRP; i++) begin
            term = c0;
            for (int k = 0; k <= i; k++) term = term & gp[k];
            c[i+1] = term;
            for (int j = 0; j <= i; j++) begin
                term = gg[j];
                for (int k = j + 1; k <= i; k++) term = term & gp[k];
                c[i+1] = c[i+1] | term;
            end
        end
        return c;
    endfunction

endpackage

// File: rtl/cla_group_lookahead.sv
// 4-bit carry-lookahead unit: internal carries plus group generate/propagate.
module cla_group_lookahead
    import cla_pkg::*;
(
    input  logic [GRP_W-1:0] g_i,
    input  logic [GRP_W-1:0] p_i,
    input  logic             c_i,
    output logic [GRP_W:1]   c_o,
    output logic             gg_o,
    output logic             gp_o
);

    assign gg_o = g_i[3] | (p_i[3] & g_i[2]) | (p_i[3] & p_i[2] & g_i[1])
                | (p_i[3] & p_i[2] & p_i[1] & g_i[0]);
    assign gp_o = &p_i;

    assign c_o[1] = g_i[0] | (p_i[0] & c_i);
    assign c_o[2] = g_i[1] | (p_i[1] & g_i[0]) | (p_i[1] & p_i[0] & c_i);
    assign c_o[3] = g_i[2] | (p_i[2] & g_i[1]) | (p_i[2] & p_i[1] & g_i[0])
                  | (p_i[2] & p_i[1] & p_i[0] & c_i);
    assign c_o[4] = gg_o | (gp_o & c_i);

endmodule

// File: rtl/cla_pipelined_adder.sv
// Two-stage pipelined carry-lookahead adder/subtractor with valid/ready flow control.
// Stage 1 registers bit and group G/P; stage 2 resolves carries and registers the result.
module cla_pipelined_adder
    import cla_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int NGRP = WIDTH / GRP_W;

    if (!width_ok(WIDTH)) begin : g_width_check
        $error("cla_pipelined_adder: WIDTH must be a multiple of 4 in 4..64");
    end

    // A beat transfers on any edge where valid & ready; ready never looks at valid.
    logic s1_adv, s2_adv;
    logic s1_valid_q, out_valid_q;

    assign s2_adv   = !out_valid_q | out_ready;
    assign s1_adv   = !s1_valid_q | s2_adv;
    assign in_ready = s1_adv;

    logic [WIDTH-1:0] bb;
    logic             c0_d;
    logic [WIDTH-1:0] p_d, g_d;
    logic [NGRP-1:0]  gg_d, gp_d;
    logic [WIDTH:1]   unused_s1_c;

    assign bb   = sub ? ~b : b;
    assign c0_d = sub ? 1'b1 : cin;
    assign p_d  = a ^ bb;
    assign g_d  = a & bb;

    for (genvar k = 0; k < NGRP; k++) begin : g_s1_grp
        cla_group_lookahead u_grp (
            .g_i  (g_d[k*GRP_W +: GRP_W]),
            .p_i  (p_d[k*GRP_W +: GRP_W]),
            .c_i  (1'b0),
            .c_o  (unused_s1_c[k*GRP_W+1 +: GRP_W]),
            .gg_o (gg_d[k]),
            .gp_o (gp_d[k])
        );
    end

    logic [WIDTH-1:0] p_q, g_q;
    logic [NGRP-1:0]  gg_q, gp_q;
    logic             c0_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            p_q        <= '0;
            g_q        <= '0;
            gg_q       <= '0;
            gp_q       <= '0;
            c0_q       <= 1'b0;
        end else if (s1_adv) begin
            s1_valid_q <= in_valid;
            if (in_valid) begin
                p_q  <= p_d;
                g_q  <= g_d;
                gg_q <= gg_d;
                gp_q <= gp_d;
                c0_q <= c0_d;
            end
        end
    end

    logic [MAX_GRP-1:0] gg_ext, gp_ext;
    logic [MAX_GRP:0]   grp_c;
    logic               unused_grp;

    always_comb begin
        gg_ext = '0;
        gp_ext = '0;
        for (int k = 0; k < NGRP; k++) begin
            gg_ext[k] = gg_q[k];
            gp_ext[k] = gp_q[k];
        end
    end

    assign grp_c      = group_carries(gg_ext, gp_ext, c0_q);
    assign unused_grp = ^grp_c[MAX_GRP:NGRP];

    logic [WIDTH:0]  c_all;
    logic [NGRP-1:0] unused_s2_gg, unused_s2_gp;

    assign c_all[0] = c0_q;

    for (genvar k = 0; k < NGRP; k++) begin : g_s2_grp
        cla_group_lookahead u_grp (
            .g_i  (g_q[k*GRP_W +: GRP_W]),
            .p_i  (p_q[k*GRP_W +: GRP_W]),
            .c_i  (grp_c[k]),
            .c_o  (c_all[k*GRP_W+1 +: GRP_W]),
            .gg_o (unused_s2_gg[k]),
            .gp_o (unused_s2_gp[k])
        );
    end

    logic [WIDTH-1:0] sum_d, sum_q;
    logic             cout_d, cout_q, ovf_d, ovf_q;

    assign sum_d  = p_q ^ c_all[WIDTH-1:0];
    assign cout_d = c_all[WIDTH];
    assign ovf_d  = c_all[WIDTH] ^ c_all[WIDTH-1];

    // Result registers only load on a real beat, so they hold while stalled or idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            sum_q       <= '0;
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
        end else if (s2_adv) begin
            out_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                sum_q  <= sum_d;
                cout_q <= cout_d;
                ovf_q  <= ovf_d;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_cla_pipelined_adder.sv
// Directed and randomised checks of cla_pipelined_adder at WIDTH=32,
// with an expected-result queue drained by an output monitor.
module tb_cla_pipelined_adder;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid, in_ready;
    logic [W-1:0] a, b;
    logic         cin, sub;
    logic         out_valid, out_ready;
    logic [W-1:0] sum;
    logic         cout, ovf;

    cla_pipelined_adder #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    int           checks   = 0;
    int           failures = 0;
    logic [W+1:0] exp_q[$];   // {cout, ovf, sum}
    logic         neg_rdy, neg_ov;
    logic         rand_done;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [W+1:0] model(input logic [W-1:0] a_v, input logic [W-1:0] b_v,
                                           input logic cin_v, input logic sub_v);
        logic [W-1:0] bbv;
        logic         c0v;
        logic [W:0]   s;
        logic         v;
        bbv = sub_v ? ~b_v : b_v;
        c0v = sub_v ? 1'b1 : cin_v;
        s   = {1'b0, a_v} + {1'b0, bbv} + {{W{1'b0}}, c0v};
        v   = (a_v[W-1] == bbv[W-1]) && (s[W-1] != a_v[W-1]);
        return {s[W], v, s[W-1:0]};
    endfunction

    // Called just after a rising edge; returns just after the accepting edge with in_valid still high.
    task automatic send_beat(input logic [W-1:0] a_v, input logic [W-1:0] b_v,
                             input logic cin_v, input logic sub_v, input logic [W+1:0] e);
        int n;
        a = a_v; b = b_v; cin = cin_v; sub = sub_v; in_valid = 1'b1;
        @(negedge clk);
        neg_rdy = in_ready;
        neg_ov  = out_valid;
        n = 0;
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            check("send_timeout", 64'd0, 64'd1);
            in_valid = 1'b0;
        end else begin
            exp_q.push_back(e);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("drain_empty", 64'(exp_q.size()), 64'd0);
    endtask

    // Output monitor: a negedge with valid & ready means a transfer on the next rising edge.
    logic [W+1:0] mon_e;
    logic         prev_stall = 1'b0;
    logic [W+2:0] prev_word;

    always @(negedge clk) begin
        if (rst) begin
            prev_stall <= 1'b0;
        end else begin
            if (prev_stall)
                check("stall_hold", 64'({out_valid, cout, ovf, sum}), 64'({1'b1, prev_word[W+1:0]}));
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("out_unexpected", 64'd1, 64'd0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("sum",  64'(sum),  64'(mon_e[W-1:0]));
                    check("cout", 64'(cout), 64'(mon_e[W+1]));
                    check("ovf",  64'(ovf),  64'(mon_e[W]));
                end
            end
            prev_stall <= out_valid && !out_ready;
            prev_word  <= {out_valid, cout, ovf, sum};
        end
    end

    logic [W-1:0] dv_a [9] = '{32'h0000_0005, 32'h7FFF_FFFF, 32'h8000_0000, 32'h8000_0000,
                               32'h0000_0003, 32'h0000_000A, 32'h1234_5678, 32'hFFFF_FFFF,
                               32'h0F0F_0F0F};
    logic [W-1:0] dv_b [9] = '{32'h0000_0007, 32'h0000_0001, 32'h0000_0001, 32'h8000_0000,
                               32'h0000_0003, 32'h0000_0003, 32'h1111_1111, 32'hFFFF_FFFF,
                               32'h0101_0101};
    logic         dv_c [9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    logic         dv_s [9] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    logic [W+1:0] dv_e [9] = '{34'h0_FFFF_FFFE, 34'h1_8000_0000, 34'h3_7FFF_FFFF, 34'h3_0000_0000,
                               34'h2_0000_0000, 34'h2_0000_0007, 34'h0_2345_678A, 34'h2_FFFF_FFFF,
                               34'h0_1010_1010};

    initial begin
        #500000;
        failures++;
        $display("FAIL watchdog observed=timeout expected=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] ra, rb;
        logic         rc, rs;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        a = '0; b = '0; cin = 1'b0; sub = 1'b0; rand_done = 1'b0;

        #1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_sum",       64'(sum),       64'd0);
        check("rst_cout",      64'(cout),      64'd0);
        check("rst_ovf",       64'(ovf),       64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        check("post_rst_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk); #1;

        // Carry through all bits; result appears two edges after acceptance.
        send_beat(32'hFFFF_FFFF, 32'h0, 1'b1, 1'b0, 34'h2_0000_0000);
        in_valid = 1'b0;
        @(negedge clk);
        check("lat_edge1_not_valid", 64'(out_valid), 64'd0);
        @(negedge clk);
        check("lat_edge2_valid", 64'(out_valid), 64'd1);
        @(negedge clk);
        check("valid_falls", 64'(out_valid), 64'd0);

        @(posedge clk); #1;
        for (int i = 0; i < 9; i++) send_beat(dv_a[i], dv_b[i], dv_c[i], dv_s[i], dv_e[i]);
        in_valid = 1'b0;
        drain();
        @(negedge clk);
        check("idle_valid_low", 64'(out_valid), 64'd0);
        check("idle_sum_kept",  64'(sum),       64'h1010_1010);

        // Back-to-back stream at full throughput.
        @(posedge clk); #1;
        for (int i = 0; i < 8; i++) begin
            ra = 32'h1000_0000 * i + i;
            rb = 32'h0F0F_0F0F ^ i;
            rc = i[0];
            rs = (i % 3 == 0);
            send_beat(ra, rb, rc, rs, model(ra, rb, rc, rs));
            check("b2b_in_ready",  64'(neg_rdy), 64'd1);
            check("b2b_out_valid", 64'(neg_ov),  (i >= 2) ? 64'd1 : 64'd0);
        end
        in_valid = 1'b0;
        @(negedge clk);
        check("b2b_tail_valid7", 64'(out_valid), 64'd1);
        @(negedge clk);
        check("b2b_tail_valid8", 64'(out_valid), 64'd1);
        @(negedge clk);
        check("b2b_tail_empty",  64'(out_valid), 64'd0);
        drain();

        // Backpressure: third beat must wait while two are held.
        @(posedge clk); #1;
        out_ready = 1'b0;
        send_beat(32'd100, 32'd23, 1'b0, 1'b0, 34'h0_0000_007B);
        check("bp_rdy_beat1", 64'(neg_rdy), 64'd1);
        send_beat(32'h40, 32'h41, 1'b0, 1'b1, 34'h0_FFFF_FFFF);
        check("bp_rdy_beat2", 64'(neg_rdy), 64'd1);
        a = 32'hFFFF_FFF0; b = 32'h20; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
        @(negedge clk);
        check("bp_in_ready_low", 64'(in_ready),  64'd0);
        check("bp_out_valid",    64'(out_valid), 64'd1);
        check("bp_held_sum",     64'(sum),       64'h7B);
        repeat (3) begin
            @(negedge clk);
            check("bp_hold_sum",   64'(sum),      64'h7B);
            check("bp_hold_ready", 64'(in_ready), 64'd0);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        send_beat(32'hFFFF_FFF0, 32'h20, 1'b0, 1'b0, 34'h2_0000_0010);
        in_valid = 1'b0;
        drain();

        // Asynchronous reset with two beats in flight.
        @(posedge clk); #1;
        out_ready = 1'b0;
        send_beat(32'd11, 32'd22, 1'b0, 1'b0, 34'h0_0000_0021);
        send_beat(32'd1,  32'd1,  1'b0, 1'b0, 34'h0_0000_0002);
        in_valid = 1'b0;
        @(negedge clk);
        check("pre_rst_valid", 64'(out_valid), 64'd1);
        #2 rst = 1'b1;
        #1;
        check("arst_out_valid", 64'(out_valid), 64'd0);
        check("arst_sum",       64'(sum),       64'd0);
        check("arst_cout",      64'(cout),      64'd0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        send_beat(32'd1, 32'd2, 1'b0, 1'b0, 34'h0_0000_0003);
        in_valid = 1'b0;
        @(negedge clk);
        check("rst_new_lat1", 64'(out_valid), 64'd0);
        @(negedge clk);
        check("rst_new_lat2", 64'(out_valid), 64'd1);
        check("rst_new_sum",  64'(sum),       64'd3);
        drain();

        // Random operands with random gaps and random downstream stalls.
        @(posedge clk); #1;
        fork
            begin
                for (int i = 0; i < 400; i++) begin
                    int gap;
                    gap = $urandom_range(0, 2);
                    if (gap != 0) begin
                        in_valid = 1'b0;
                        repeat (gap) @(posedge clk);
                        #1;
                    end
                    ra = ($urandom_range(0, 7) == 0) ? 32'h7FFF_FFFF : W'($urandom());
                    rb = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : W'($urandom());
                    rc = 1'($urandom_range(0, 1));
                    rs = 1'($urandom_range(0, 1));
                    send_beat(ra, rb, rc, rs, model(ra, rb, rc, rs));
                end
                in_valid = 1'b0;
                rand_done = 1'b1;
            end
            begin
                while (!rand_done) begin
                    @(posedge clk); #1;
                    out_ready = 1'($urandom_range(0, 1));
                end
            end
        join
        out_ready = 1'b1;
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
